// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the CPU (default owner) and
// the two UART engines (loader, dumper). Ownership only moves at the clock edge
// that ends a boundary cycle, so a write address phase is never split from its
// commit. The bus mux is purely combinational on the owner register.
// Optional feature: define ARB_TIMEOUT_EN to bound UART ownership to
// TIMEOUT_CYCLES consecutive cycles. A requester that is forced off the bus is
// blocked from regrant until it drops its request.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk_ext,
    input  logic       ext_rst,
    input  logic [9:0] cpu_addr_data,
    input  logic       cpu_read_write,
    input  logic       cpu_write_commit,
    input  logic       ld_req,
    output logic       ld_gnt,
    input  logic [9:0] ld_addr_data,
    input  logic       ld_read_write,
    input  logic       ld_write_commit,
    input  logic       dmp_req,
    output logic       dmp_gnt,
    input  logic [9:0] dmp_addr_data,
    input  logic       dmp_read_write,
    input  logic       dmp_write_commit,
    output logic [9:0] mem_addr_data,
    output logic       mem_read_write,
    output logic       mem_write_commit,
    output logic       cpu_hold,
    output logic [1:0] owner,
    output logic       proto_err,
    output logic       timeout
);

    // Encoding is visible on the owner port, so keep it fixed.
    typedef enum logic [1:0] {
        OWN_CPU = 2'd0,
        OWN_LD  = 2'd1,
        OWN_DMP = 2'd2
    } own_e;

    own_e state_q, state_d;
    logic boundary;
    logic err_set;
    logic ld_ok, dmp_ok;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          ld_blk_q, dmp_blk_q;
    logic          timeout_q;
    logic          expired;
    logic          force_rel;

    // Counter holds (cycles owned - 1); once it reaches CNT_MAX the current
    // cycle is the last one allowed, and release waits for a boundary.
    assign expired = (state_q != OWN_CPU) && (cnt_q == CNT_MAX);
    assign ld_ok   = ld_req  & ~ld_blk_q;
    assign dmp_ok  = dmp_req & ~dmp_blk_q;
    assign timeout = timeout_q;
`else
    assign ld_ok   = ld_req;
    assign dmp_ok  = dmp_req;
    assign timeout = 1'b0;
`endif

    // Route the owner's bus to memory; non-owner inputs never reach it.
    always_comb begin
        mem_addr_data    = cpu_addr_data;
        mem_read_write   = cpu_read_write;
        mem_write_commit = cpu_write_commit;
        case (state_q)
            OWN_LD: begin
                mem_addr_data    = ld_addr_data;
                mem_read_write   = ld_read_write;
                mem_write_commit = ld_write_commit;
            end
            OWN_DMP: begin
                mem_addr_data    = dmp_addr_data;
                mem_read_write   = dmp_read_write;
                mem_write_commit = dmp_write_commit;
            end
            default: ;
        endcase
    end

    // Only a write address phase (rw=0, commit=0) pins ownership.
    assign boundary = mem_read_write | mem_write_commit;

    // Next owner: dumper beats loader beats CPU; a UART owner is never
    // preempted by the other UART, and a release hands over directly.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
`ifdef ARB_TIMEOUT_EN
        force_rel = 1'b0;
`endif
        case (state_q)
            OWN_CPU: begin
                if (boundary) begin
                    if (dmp_ok)     state_d = OWN_DMP;
                    else if (ld_ok) state_d = OWN_LD;
                end
            end
            OWN_LD: begin
                if (!ld_req) begin
                    // Dropping mid address phase is an error, but still release.
                    err_set = ~boundary;
                    state_d = dmp_ok ? OWN_DMP : OWN_CPU;
                end
`ifdef ARB_TIMEOUT_EN
                else if (expired && boundary) begin
                    force_rel = 1'b1;
                    state_d   = dmp_ok ? OWN_DMP : OWN_CPU;
                end
`endif
            end
            OWN_DMP: begin
                if (!dmp_req) begin
                    err_set = ~boundary;
                    state_d = ld_ok ? OWN_LD : OWN_CPU;
                end
`ifdef ARB_TIMEOUT_EN
                else if (expired && boundary) begin
                    force_rel = 1'b1;
                    state_d   = ld_ok ? OWN_LD : OWN_CPU;
                end
`endif
            end
            default: state_d = OWN_CPU;
        endcase
    end

    // Owner register and sticky protocol error; reset returns the bus to the CPU.
    always_ff @(posedge clk_ext or posedge ext_rst) begin
        if (ext_rst) begin
            state_q   <= OWN_CPU;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            proto_err <= proto_err | err_set;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Ownership age, timeout pulse and per-requester regrant blocks.
    always_ff @(posedge clk_ext or posedge ext_rst) begin
        if (ext_rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            ld_blk_q  <= 1'b0;
            dmp_blk_q <= 1'b0;
        end else begin
            if (state_d != state_q || state_q == OWN_CPU) cnt_q <= '0;
            else if (!expired)                            cnt_q <= cnt_q + 1'b1;
            timeout_q <= force_rel;
            ld_blk_q  <= (ld_blk_q  & ld_req)  | (force_rel & (state_q == OWN_LD));
            dmp_blk_q <= (dmp_blk_q & dmp_req) | (force_rel & (state_q == OWN_DMP));
        end
    end
`endif

    assign owner    = state_q;
    assign ld_gnt   = (state_q == OWN_LD);
    assign dmp_gnt  = (state_q == OWN_DMP);
    assign cpu_hold = (state_q != OWN_CPU);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; one task per scenario.
module tb_mem_bus_arbiter;

    logic       clk_ext = 1'b0;
    logic       ext_rst;
    logic [9:0] cpu_addr_data, ld_addr_data, dmp_addr_data, mem_addr_data;
    logic       cpu_read_write, cpu_write_commit;
    logic       ld_req, ld_gnt, ld_read_write, ld_write_commit;
    logic       dmp_req, dmp_gnt, dmp_read_write, dmp_write_commit;
    logic       mem_read_write, mem_write_commit;
    logic       cpu_hold, proto_err, timeout;
    logic [1:0] owner;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_ext(clk_ext), .ext_rst(ext_rst),
        .cpu_addr_data(cpu_addr_data), .cpu_read_write(cpu_read_write),
        .cpu_write_commit(cpu_write_commit),
        .ld_req(ld_req), .ld_gnt(ld_gnt), .ld_addr_data(ld_addr_data),
        .ld_read_write(ld_read_write), .ld_write_commit(ld_write_commit),
        .dmp_req(dmp_req), .dmp_gnt(dmp_gnt), .dmp_addr_data(dmp_addr_data),
        .dmp_read_write(dmp_read_write), .dmp_write_commit(dmp_write_commit),
        .mem_addr_data(mem_addr_data), .mem_read_write(mem_read_write),
        .mem_write_commit(mem_write_commit),
        .cpu_hold(cpu_hold), .owner(owner), .proto_err(proto_err), .timeout(timeout)
    );

    always #5 clk_ext = ~clk_ext;

    // Land 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk_ext);
        #1;
    endtask

    task automatic test_reset();
        ext_rst = 1'b1;
        cpu_addr_data = 10'h000; cpu_read_write = 1'b1; cpu_write_commit = 1'b0;
        ld_req = 1'b1; ld_addr_data = 10'h000; ld_read_write = 1'b1; ld_write_commit = 1'b0;
        dmp_req = 1'b0; dmp_addr_data = 10'h000; dmp_read_write = 1'b1; dmp_write_commit = 1'b0;
        #2;
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
        checks++; if ({ld_gnt, dmp_gnt, cpu_hold} !== 3'b000) begin errors++; $display("FAIL reset_gnts got %b want 000", {ld_gnt, dmp_gnt, cpu_hold}); end
        checks++; if ({proto_err, timeout} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {proto_err, timeout}); end
        step(); step();
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL reset_no_grant got %b want 0", ld_gnt); end
        ld_req = 1'b0;
        ext_rst = 1'b0;
        step();
    endtask

    task automatic test_cpu_pass();
        cpu_addr_data = 10'h3A5; cpu_read_write = 1'b1; cpu_write_commit = 1'b0;
        ld_addr_data = 10'h111; ld_write_commit = 1'b1;
        #1;
        checks++; if (mem_addr_data !== 10'h3A5) begin errors++; $display("FAIL cpu_addr got %h want 3a5", mem_addr_data); end
        checks++; if ({mem_read_write, mem_write_commit} !== 2'b10) begin errors++; $display("FAIL cpu_ctl got %b want 10", {mem_read_write, mem_write_commit}); end
        checks++; if (owner !== 2'd0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL cpu_owner got %0d/%b want 0/0", owner, cpu_hold); end
        ld_write_commit = 1'b0;
        step();
    endtask

    task automatic test_ld_after_write();
        // cycle N: CPU write address phase, loader requests
        cpu_addr_data = 10'h155; cpu_read_write = 1'b0; cpu_write_commit = 1'b0;
        ld_req = 1'b1; ld_addr_data = 10'h2C3; ld_read_write = 1'b1;
        #1;
        checks++; if (mem_addr_data !== 10'h155 || mem_write_commit !== 1'b0) begin errors++; $display("FAIL wr_addr_phase got %h/%b want 155/0", mem_addr_data, mem_write_commit); end
        step();
        // cycle N+1: CPU commit must still pass through
        cpu_write_commit = 1'b1;
        #1;
        checks++; if (mem_addr_data !== 10'h155 || mem_write_commit !== 1'b1) begin errors++; $display("FAIL wr_commit got %h/%b want 155/1", mem_addr_data, mem_write_commit); end
        checks++; if (ld_gnt !== 1'b0 || owner !== 2'd0) begin errors++; $display("FAIL wr_no_split got %b/%0d want 0/0", ld_gnt, owner); end
        step();
        // cycle N+2: loader owns
        checks++; if (ld_gnt !== 1'b1 || cpu_hold !== 1'b1 || owner !== 2'd1) begin errors++; $display("FAIL ld_grant got %b/%b/%0d want 1/1/1", ld_gnt, cpu_hold, owner); end
        checks++; if (mem_addr_data !== 10'h2C3 || mem_read_write !== 1'b1) begin errors++; $display("FAIL ld_mux got %h/%b want 2c3/1", mem_addr_data, mem_read_write); end
        cpu_addr_data = 10'h3FF; cpu_read_write = 1'b0; cpu_write_commit = 1'b1;
        #1;
        checks++; if (mem_addr_data !== 10'h2C3 || mem_write_commit !== 1'b0) begin errors++; $display("FAIL non_owner_ignored got %h/%b want 2c3/0", mem_addr_data, mem_write_commit); end
        cpu_read_write = 1'b1; cpu_write_commit = 1'b0;
    endtask

    task automatic test_handoff();
        dmp_req = 1'b1; dmp_addr_data = 10'h0F0; dmp_read_write = 1'b1;
        step();
        checks++; if (owner !== 2'd1 || dmp_gnt !== 1'b0) begin errors++; $display("FAIL no_preempt got %0d/%b want 1/0", owner, dmp_gnt); end
        ld_req = 1'b0; ld_read_write = 1'b0; ld_write_commit = 1'b1;
        step();
        checks++; if (dmp_gnt !== 1'b1 || ld_gnt !== 1'b0 || owner !== 2'd2) begin errors++; $display("FAIL handoff got %b/%b/%0d want 1/0/2", dmp_gnt, ld_gnt, owner); end
        checks++; if (cpu_hold !== 1'b1 || proto_err !== 1'b0) begin errors++; $display("FAIL handoff_hold got %b/%b want 1/0", cpu_hold, proto_err); end
        checks++; if (mem_addr_data !== 10'h0F0) begin errors++; $display("FAIL dmp_mux got %h want 0f0", mem_addr_data); end
        ld_read_write = 1'b1; ld_write_commit = 1'b0;
        dmp_req = 1'b0;
        step();
        checks++; if (owner !== 2'd0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL dmp_release got %0d/%b want 0/0", owner, cpu_hold); end
    endtask

    task automatic test_simultaneous();
        ld_req = 1'b1; dmp_req = 1'b1;
        step();
        checks++; if (dmp_gnt !== 1'b1 || ld_gnt !== 1'b0 || owner !== 2'd2) begin errors++; $display("FAIL simul_prio got %b/%b/%0d want 1/0/2", dmp_gnt, ld_gnt, owner); end
        step();
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL simul_ld_wait got %b want 0", ld_gnt); end
        dmp_req = 1'b0;
        step();
        checks++; if (ld_gnt !== 1'b1 || dmp_gnt !== 1'b0 || owner !== 2'd1) begin errors++; $display("FAIL simul_direct got %b/%b/%0d want 1/0/1", ld_gnt, dmp_gnt, owner); end
        ld_req = 1'b0;
        step();
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL simul_back_cpu got %0d want 0", owner); end
    endtask

    task automatic test_proto_err();
        ld_req = 1'b1;
        step();
        ld_read_write = 1'b0; ld_write_commit = 1'b0; ld_req = 1'b0;
        step();
        checks++; if (proto_err !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL proto_set got %b/%0d want 1/0", proto_err, owner); end
        ld_read_write = 1'b1;
        step(); step();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b want 1", proto_err); end
    endtask

    task automatic test_reset_mid_write();
        ld_req = 1'b1;
        step();
        ld_addr_data = 10'h1AB; ld_read_write = 1'b0; ld_write_commit = 1'b0;
        cpu_addr_data = 10'h0C3; cpu_read_write = 1'b1;
        #2;
        ext_rst = 1'b1;
        #1;
        checks++; if (owner !== 2'd0 || ld_gnt !== 1'b0 || cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_mid got %0d/%b/%b want 0/0/0", owner, ld_gnt, cpu_hold); end
        checks++; if (mem_addr_data !== 10'h0C3 || proto_err !== 1'b0) begin errors++; $display("FAIL rst_mux got %h/%b want 0c3/0", mem_addr_data, proto_err); end
        ld_req = 1'b0; ld_read_write = 1'b1;
        step();
        ext_rst = 1'b0;
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        ld_req = 1'b1;
        step();
        checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL to_grant got %b want 1", ld_gnt); end
        for (int k = 2; k <= 16; k++) begin
            step();
            checks++; if (ld_gnt !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL to_hold cycle %0d got %b/%b want 1/0", k, ld_gnt, timeout); end
        end
        step();
        checks++; if (ld_gnt !== 1'b0 || timeout !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL to_release got %b/%b/%0d want 0/1/0", ld_gnt, timeout, owner); end
        step();
        checks++; if (ld_gnt !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL to_blocked got %b/%b want 0/0", ld_gnt, timeout); end
        ld_req = 1'b0;
        step();
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL to_low got %b want 0", ld_gnt); end
        ld_req = 1'b1;
        step();
        checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL to_regrant got %b want 1", ld_gnt); end
        ld_req = 1'b0;
        step();
    endtask
`else
    task automatic test_timeout();
        ld_req = 1'b1;
        step();
        for (int k = 1; k <= 40; k++) begin
            checks++; if (ld_gnt !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL unbounded cycle %0d got %b/%b want 1/0", k, ld_gnt, timeout); end
            step();
        end
        ld_req = 1'b0;
        step();
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL unbounded_release got %0d want 0", owner); end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_pass();
        test_ld_after_write();
        test_handoff();
        test_simultaneous();
        test_proto_err();
        test_reset_mid_write();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: maximum consecutive cycles a UART requester may own the bus (used only with ARB_TIMEOUT_EN).
REQ-002 clk_ext  in  1  system clock; all state changes on rising edge.
REQ-003 ext_rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_addr_data / cpu_read_write / cpu_write_commit  in  10/1/1  CPU memory bus (default owner, no handshake).
REQ-005 ld_req  in  1  UART loader requests bus; held high for the whole ownership.
REQ-006 ld_gnt  out  1  loader owns bus.
REQ-007 ld_addr_data / ld_read_write / ld_write_commit  in  10/1/1  loader memory bus.
REQ-008 dmp_req  in  1  UART dumper requests bus.
REQ-009 dmp_gnt  out  1  dumper owns bus.
REQ-010 dmp_addr_data / dmp_read_write / dmp_write_commit  in  10/1/1  dumper memory bus.
REQ-011 mem_addr_data / mem_read_write / mem_write_commit  out  10/1/1  bus to memory.
REQ-012 cpu_hold  out  1  high while CPU does not own bus; drives CPU reset.
REQ-013 owner  out  2  current owner: 0 CPU, 1 loader, 2 dumper.
REQ-014 proto_err  out  1  sticky protocol-violation flag.
REQ-015 timeout  out  1  one-cycle pulse on forced release.

Function
REQ-016 Owner state SHALL be one register with states OWN_CPU, OWN_LD, OWN_DMP; encoding equals owner output.
REQ-017 mem_* SHALL be a combinational mux of the current owner's inputs, zero added latency.
REQ-018 Address phase = owner's bus shows read_write=0, write_commit=0; boundary = any other cycle (read, commit, or halt 1/1).
REQ-019 Ownership SHALL change only at a clock edge ending a boundary cycle; never between a write address phase and its commit.
REQ-020 Priority dmp_req > ld_req > CPU; no preemption between loader and dumper.
REQ-021 OWN_CPU: if dmp_req or ld_req high and boundary, next state is highest-priority requester.
REQ-022 OWN_LD/OWN_DMP: if own req low and boundary, next state is the other UART requester if its req is high, else OWN_CPU (direct handoff, no idle cycle).
REQ-023 Own req dropping during an address phase SHALL set proto_err and release at that edge anyway.
REQ-024 ld_gnt, dmp_gnt, cpu_hold SHALL be decoded from the owner register; grant earliest one cycle after req rises.
REQ-025 Requests asserted simultaneously with a release SHALL be resolved by REQ-020 in the same cycle.
REQ-026 Inputs from non-owners SHALL be ignored entirely.
REQ-027 proto_err SHALL clear only on reset.

Reset
REQ-028 ext_rst SHALL immediately force owner=OWN_CPU, ld_gnt=0, dmp_gnt=0, cpu_hold=0, proto_err=0, timeout=0, counter and block bits cleared.
REQ-029 Reset mid-write SHALL abandon the transfer; mem_* follows cpu_* immediately.
REQ-030 First grant after reset SHALL occur no earlier than the first edge with ext_rst low.

Configuration
REQ-031 Macro ARB_TIMEOUT_EN defined: counter counts consecutive cycles of UART ownership, resets on each ownership change; at TIMEOUT_CYCLES the owner is released at the next boundary, timeout pulses one cycle, and that requester is blocked from regrant until its req goes low.
REQ-032 Macro undefined: no counter or block bits synthesized; timeout tied 0; ownership unbounded.

Verification
REQ-033 Reset, CPU read addr 0x3A5 -> mem_addr_data=0x3A5, owner=0, cpu_hold=0.
REQ-034 CPU write addr phase (rw=0,c=0) cycle N with ld_req rising cycle N -> CPU commit at N+1 passes through, ld_gnt=1 and cpu_hold=1 from N+2.
REQ-035 Loader owns, dmp_req rises, ld_req falls on a commit cycle -> dmp_gnt=1 next cycle, ld_gnt=0, owner=2, no CPU cycle between.
REQ-036 ld_req and dmp_req rise same cycle from OWN_CPU at boundary -> dmp_gnt=1 next cycle, ld_gnt stays 0 until dumper releases.
REQ-037 Loader drops ld_req during address phase -> proto_err=1 next cycle, owner=0, proto_err stays 1 until ext_rst.
REQ-038 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, ld_req held with reads -> release after cycle 16, timeout pulse, ld_gnt stays 0 until ld_req toggles low then high.
